vram_port_arbiter: RTL and testbench
====================================

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 17, video memory address width (320x... VRAM, 17-bit as video_memory port A).
REQ-002 Parameter: DATA_W, default 8, VRAM data width.
REQ-003 Parameter: MAX_BURST, default 16, max consecutive locked transfers granted to one requester (range 1..255).
REQ-004 Ports (name  direction  width  meaning):
- clk_25mhz  in  1  pixel/system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  requester n has a valid command.
- we0 / we1  in  1  1=write, 0=read.
- lock0 / lock1  in  1  requester n wants to keep the port for its next transfer (burst).
- addr0 / addr1  in  ADDR_W  command address.
- wdata0 / wdata1  in  DATA_W  write data.
- rdy0 / rdy1  out  1  arbiter accepts requester n's command this cycle.
- rvalid0 / rvalid1  out  1  read data for requester n valid this cycle.
- rdata  out  DATA_W  read data, shared by both requesters.
- mem_en  out  1  VRAM port A command strobe.
- mem_we  out  1  VRAM port A write enable.
- mem_addr  out  ADDR_W  VRAM port A address.
- mem_wdata  out  DATA_W  VRAM port A write data.
- mem_rdata  in  DATA_W  VRAM port A read data, valid one cycle after mem_en sampled.
- busy  out  1  a lock is held or a read is in flight.

Function
REQ-005 A transfer for requester n SHALL occur at a rising edge where reqn=1 and rdyn=1; the requester SHALL hold req/we/addr/wdata stable until that edge.
REQ-006 rdy0 and rdy1 SHALL be combinational from state and req inputs, never both 1 in the same cycle, and rdyn=1 only if reqn=1.
REQ-007 Arbiter state SHALL be one of FREE, LOCK0, LOCK1, plus a 1-bit last-served pointer and a burst counter.
REQ-008 FREE: if only one requester asserts req it SHALL get rdy; if both, the requester not equal to last-served SHALL get rdy (round-robin).
REQ-009 LOCKn: requester n SHALL get rdy whenever reqn=1; the other requester SHALL get rdy=0, except when reqn=0, in which case the state SHALL behave as FREE that cycle.
REQ-010 On a transfer by n with lockn=1 the state SHALL become LOCKn and the burst counter SHALL increment; with lockn=0 the state SHALL become FREE and the counter clear.
REQ-011 When the burst counter reaches MAX_BURST and the other requester is requesting, the state SHALL return to FREE and the counter clear, regardless of lockn.
REQ-012 Last-served SHALL update to n on every transfer by n.
REQ-013 On transfer at edge E0, mem_en=1, mem_we=wen, mem_addr=addrn, mem_wdata=wdatan SHALL be registered and presented during the following cycle; mem_en and mem_we SHALL be 0 in cycles with no transfer at the preceding edge; mem_addr/mem_wdata hold their last value.
REQ-014 For a read transfer at E0, rvalidn SHALL be 1 exactly in the cycle two cycles after E0 (latency 2), with rdata = mem_rdata passed through combinationally; writes SHALL produce no rvalid.
REQ-015 Back-to-back transfers (one per cycle) SHALL be supported; read returns SHALL preserve issue order and requester tag via a 2-stage tag pipeline.
REQ-016 busy SHALL equal (state!=FREE) OR any read in the tag pipeline.

Reset
REQ-017 reset_n=0 SHALL asynchronously force: state FREE, last-served=1 (requester 0 wins first tie), burst counter 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, tag pipeline empty, rvalid0=rvalid1=0.
REQ-018 Reset asserted with a read in flight SHALL discard that read; no rvalid SHALL follow reset release.

Verification
REQ-019 Tie after reset: req0=req1=1 (reads, addr0=0x00010, addr1=0x00020) -> rdy0 first cycle, rdy1 next; mem_addr 0x00010 then 0x00020; rvalid0 then rvalid1 on consecutive cycles, 2 cycles after each transfer.
REQ-020 Single write: req1=1, we1=1, addr1=0x1F3FF, wdata1=0xA5 -> rdy1 same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x1F3FF, mem_wdata=0xA5; no rvalid1.
REQ-021 Lock burst, MAX_BURST=4: req0+lock0 held, req1 held -> four consecutive rdy0, then rdy1 once, then requester 0 again.
REQ-022 Lock released: requester 0 in LOCK0 drops req0 while req1=1 -> rdy1 in that same cycle; state FREE after transfer with lock1=0.
REQ-023 Reset mid-read: read transfer at E0, reset_n low for one cycle before E0+2 -> rvalid0 never asserts; all outputs at reset values; busy=0.
REQ-024 Throughput: req0 continuous reads with req1=0 -> one transfer per cycle, rvalid0 continuous after 2-cycle latency, rdata tracks mem_rdata.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for the single VRAM command port.
// Round-robin on ties, optional bounded burst locking, registered memory
// command, and a 2-stage read tag pipeline that routes returning data.
module vram_port_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              rdy0,
  output logic              rdy1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {FREE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [7:0]          burst_q, burst_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  // index 0: read issued at the last edge, index 1: data on mem_rdata now
  logic [1:0]          rd_vld_q, rd_vld_d;
  logic [1:0]          rd_tag_q, rd_tag_d;

  logic                expired, own0, own1, arb;
  logic                xfer, sel, x_lock, x_other, x_we;
  logic [7:0]          burst_base;
  logic [8:0]          burst_inc;
  logic [7:0]          burst_sat;

  // Grant: a lock owner keeps the port while requesting unless its burst is
  // spent and the other side is waiting; otherwise round-robin arbitration.
  always_comb begin
    expired = (burst_q >= MAX_B);
    own0    = (state_q == LOCK0) && req0 && !(expired && req1);
    own1    = (state_q == LOCK1) && req1 && !(expired && req0);
    arb     = !own0 && !own1;
    rdy0    = own0 || (arb && req0 && (!req1 || last_q));
    rdy1    = own1 || (arb && req1 && (!req0 || !last_q));
  end

  // Next state: lock/burst bookkeeping, memory command and tag pipeline.
  always_comb begin
    xfer       = rdy0 || rdy1;
    sel        = rdy1;
    x_lock     = sel ? lock1 : lock0;
    x_other    = sel ? req0 : req1;
    x_we       = sel ? we1 : we0;
    // a burst counts only the current owner's consecutive transfers
    burst_base = (state_q == (sel ? LOCK1 : LOCK0)) ? burst_q : 8'd0;
    burst_inc  = {1'b0, burst_base} + 9'd1;
    burst_sat  = (burst_inc >= {1'b0, MAX_B}) ? MAX_B : burst_inc[7:0];

    state_d     = state_q;
    last_d      = last_q;
    burst_d     = burst_q;
    mem_en_d    = xfer;
    mem_we_d    = xfer && x_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_vld_d    = {rd_vld_q[0], xfer && !x_we};
    rd_tag_d    = {rd_tag_q[0], sel};

    if (xfer) begin
      last_d      = sel;
      mem_addr_d  = sel ? addr1 : addr0;
      mem_wdata_d = sel ? wdata1 : wdata0;
      if (x_lock && !((burst_inc >= {1'b0, MAX_B}) && x_other)) begin
        state_d = sel ? LOCK1 : LOCK0;
        burst_d = burst_sat;
      end else begin
        state_d = FREE;
        burst_d = 8'd0;
      end
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FREE;
      last_q      <= 1'b1;
      burst_q     <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_vld_q    <= 2'b00;
      rd_tag_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= rd_vld_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid0   = rd_vld_q[1] && !rd_tag_q[1];
  assign rvalid1   = rd_vld_q[1] && rd_tag_q[1];
  assign rdata     = mem_rdata;
  assign busy      = (state_q != FREE) || (|rd_vld_q);

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios plus random traffic, all
// checked against a rule-level reference model and a VRAM model.
module tb_vram_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk_25mhz = 1'b0;
  logic reset_n;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic rdy0, rdy1, rvalid0, rvalid1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad = 0;

  vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_25mhz(clk_25mhz), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .rdy0(rdy0), .rdy1(rdy1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  always #20 clk_25mhz = ~clk_25mhz;

  // synchronous VRAM port A
  logic [DW-1:0] vmem [0:(1<<AW)-1];
  always @(posedge clk_25mhz) begin
    if (mem_en) begin
      if (mem_we) vmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= vmem[mem_addr];
    end
  end

  // reference model: owner (0 none, 1 req0, 2 req1), last served, burst count
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_own, m_cnt;
  bit m_last;
  bit e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  bit wp;                       // accepted write not yet in memory
  logic [AW-1:0] wp_addr;
  logic [DW-1:0] wp_data;
  bit s1v, s2v, s1t, s2t;       // outstanding reads, in issue order
  logic [DW-1:0] s1d, s2d;
  bit p0, p1;                   // command waiting for its grant

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 1'b1;
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    wp = 0; s1v = 0; s2v = 0; s1t = 0; s2t = 0; s1d = '0; s2d = '0;
    p0 = 0; p1 = 0;
  endtask

  task automatic drive(input bit r0, input bit w0, input bit l0, input int a0, input int d0,
                       input bit r1, input bit w1, input bit l1, input int a1, input int d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = AW'(a0); wdata0 = DW'(d0);
    req1 = r1; we1 = w1; lock1 = l1; addr1 = AW'(a1); wdata1 = DW'(d1);
    #1;
  endtask

  // one clock: check grants, advance model, check registered outputs
  task automatic step();
    bit g0, g1, sel, wr, lk, oth;
    int c;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    g0 = 0; g1 = 0; rd = '0;
    if (m_own == 1 && req0 && !(m_cnt >= MB && req1)) g0 = 1;
    else if (m_own == 2 && req1 && !(m_cnt >= MB && req0)) g1 = 1;
    else if (req0 && req1) begin if (m_last) g0 = 1; else g1 = 1; end
    else if (req0) g0 = 1;
    else if (req1) g1 = 1;
    chk("rdy0", rdy0, g0);
    chk("rdy1", rdy1, g1);
    p0 = req0 && !g0;
    p1 = req1 && !g1;
    if (wp) begin ref_mem[wp_addr] = wp_data; wp = 0; end
    wr = 0;
    sel = g1;
    if (g0 || g1) begin
      wr  = sel ? we1 : we0;
      lk  = sel ? lock1 : lock0;
      oth = sel ? req0 : req1;
      a   = sel ? addr1 : addr0;
      d   = sel ? wdata1 : wdata0;
      if (lk) begin
        c = ((m_own == (sel ? 2 : 1)) ? m_cnt : 0) + 1;
        if (c > MB) c = MB;
        if (c >= MB && oth) begin m_own = 0; m_cnt = 0; end
        else begin m_own = sel ? 2 : 1; m_cnt = c; end
      end else begin
        m_own = 0; m_cnt = 0;
      end
      m_last = sel;
      e_en = 1; e_we = wr; e_addr = a; e_wd = d;
      if (wr) begin wp = 1; wp_addr = a; wp_data = d; end
      else rd = ref_mem[a];
    end else begin
      e_en = 0; e_we = 0;
    end
    s2v = s1v; s2t = s1t; s2d = s1d;
    s1v = (g0 || g1) && !wr; s1t = sel; s1d = rd;
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("rvalid0", rvalid0, s2v && !s2t);
    chk("rvalid1", rvalid1, s2v && s2t);
    if (s2v) chk("rdata", rdata, s2d);
    chk("busy", busy, (m_own != 0) || s1v || s2v);
  endtask

  // reset for one clock edge, entered mid-cycle
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      vmem[i] = DW'(i ^ (i >> 8));
      ref_mem[i] = DW'(i ^ (i >> 8));
    end
    model_reset();
    @(negedge clk_25mhz);
    do_reset();

    // tie after reset: requester 0 first, then 1; returns in order
    drive(1, 0, 0, 'h10, 0, 1, 0, 0, 'h20, 0);
    chk("tie_rdy0", {rdy0, rdy1}, 2'b10);
    step();
    chk("tie_addr0", mem_addr, 'h10);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 'h20, 0);
    chk("tie_rdy1", {rdy0, rdy1}, 2'b01);
    step();
    chk("tie_addr1", mem_addr, 'h20);
    chk("tie_rv0", rvalid0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("tie_rv1", rvalid1, 1);
    step();

    // single write by requester 1
    drive(0, 0, 0, 0, 0, 1, 1, 0, 'h1F3FF, 'hA5);
    chk("wr_rdy1", rdy1, 1);
    step();
    chk("wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 17'h1F3FF, 8'hA5});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // locked burst of MB, then one grant to the waiting side, then back
    for (int k = 0; k < MB; k++) begin
      drive(1, 0, 1, 'h100 + k, 0, 1, 0, 0, 'h200, 0);
      chk("burst_rdy0", {rdy0, rdy1}, 2'b10);
      step();
    end
    drive(1, 0, 1, 'h180, 0, 1, 0, 0, 'h200, 0);
    chk("burst_rdy1", {rdy0, rdy1}, 2'b01);
    step();
    drive(1, 0, 0, 'h180, 0, 1, 0, 0, 'h201, 0);
    chk("burst_back0", {rdy0, rdy1}, 2'b10);
    step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 'h201, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // lock holder goes idle: other side served the same cycle
    drive(1, 1, 1, 'h300, 'h11, 0, 0, 0, 0, 0);
    step();
    chk("lk_busy", busy, 1);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 'h301, 'h22);
    chk("lk_rdy1", {rdy0, rdy1}, 2'b01);
    step();
    chk("lk_free", busy, 0);

    // reset while a read is in flight
    drive(1, 0, 0, 'h400, 0, 0, 0, 0, 0, 0);
    step();
    do_reset();
    chk("rst_rv0_a", rvalid0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_rv0_b", rvalid0, 0);
    chk("rst_busy_b", busy, 0);

    // streaming reads by requester 0
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 'h1000 + 7 * k, 0, 0, 0, 0, 0, 0);
      chk("stream_rdy0", rdy0, 1);
      step();
      if (k >= 1) chk("stream_rv0", rvalid0, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // random traffic honouring the hold-until-accepted rule
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if (!p0) begin
          req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
          addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
        end
        if (!p1) begin
          req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
          addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
        end
        lock0 = ($urandom_range(0, 3) != 0);
        lock1 = ($urandom_range(0, 3) != 0);
        #1;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
